// File: rtl/demux_dff.sv
// rtl/demux_dff.sv - Registered 1-to-4 demux with complementary lane outputs.
// Optional frame-complete mask and pulse are enabled by defining DEMUX_FRAME_EN.
module demux_dff #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   d_in,
    input  logic               d_valid,
    input  logic [1:0]         select,
    input  logic               auto_mode,
    output logic [4*WIDTH-1:0] q,
    output logic [4*WIDTH-1:0] qbar,
    output logic [3:0]         q_valid,
    output logic [1:0]         ptr,
    output logic               frame_done
);

    logic [4*WIDTH-1:0] q_q, q_d;
    logic [4*WIDTH-1:0] qbar_q, qbar_d;
    logic [3:0]         q_valid_q, q_valid_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         lane;

    assign lane = auto_mode ? ptr_q : select;

    always_comb begin
        q_d       = q_q;
        qbar_d    = qbar_q;
        q_valid_d = 4'b0000;
        ptr_d     = ptr_q;
        if (d_valid) begin
            for (int k = 0; k < 4; k++) begin
                if (lane == 2'(k)) begin
                    q_d[k*WIDTH +: WIDTH]    = d_in;
                    qbar_d[k*WIDTH +: WIDTH] = ~d_in;
                    q_valid_d[k]             = 1'b1;
                end
            end
            if (auto_mode) begin
                ptr_d = ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q       <= '0;
            qbar_q    <= '1;
            q_valid_q <= 4'b0000;
            ptr_q     <= 2'd0;
        end else begin
            q_q       <= q_d;
            qbar_q    <= qbar_d;
            q_valid_q <= q_valid_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef DEMUX_FRAME_EN
    logic [3:0] mask_q, mask_d;
    logic       frame_done_q, frame_done_d;
    logic [3:0] mask_next;

    // The completing write both raises the pulse and starts an empty mask.
    always_comb begin
        mask_d       = mask_q;
        frame_done_d = 1'b0;
        mask_next    = mask_q | (4'b0001 << lane);
        if (d_valid) begin
            if (mask_next == 4'b1111) begin
                mask_d       = 4'b0000;
                frame_done_d = 1'b1;
            end else begin
                mask_d = mask_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q       <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;
`else
    assign frame_done = 1'b0;
`endif

    assign q       = q_q;
    assign qbar    = qbar_q;
    assign q_valid = q_valid_q;
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_demux_dff.sv
// tb/tb_demux_dff.sv - Scoreboard bench for demux_dff (WIDTH=8).
// Frame-complete expectations follow DEMUX_FRAME_EN.
module tb_demux_dff;

    localparam int W = 8;

    typedef struct packed {
        logic [4*W-1:0] q;
        logic [4*W-1:0] qbar;
        logic [3:0]     v;
        logic [1:0]     p;
        logic           fd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   d_in = '0;
    logic           d_valid = 1'b0;
    logic [1:0]     select = 2'd0;
    logic           auto_mode = 1'b0;
    logic [4*W-1:0] q, qbar;
    logic [3:0]     q_valid;
    logic [1:0]     ptr;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t e;

    logic [W-1:0] m_q [4];
    logic [1:0]   m_ptr;
    logic [3:0]   m_mask;
    logic [3:0]   m_vld;
    logic         m_fd;

    demux_dff #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid),
        .select(select), .auto_mode(auto_mode), .q(q), .qbar(qbar),
        .q_valid(q_valid), .ptr(ptr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic exp_t snap();
        exp_t x;
        for (int k = 0; k < 4; k++) begin
            x.q[k*W +: W]    = m_q[k];
            x.qbar[k*W +: W] = ~m_q[k];
        end
        x.v  = m_vld;
        x.p  = m_ptr;
        x.fd = m_fd;
        return x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_q[k] = '0;
        m_ptr = 2'd0; m_mask = 4'd0; m_vld = 4'd0; m_fd = 1'b0;
        sb.delete();
    endtask

    // Drives one cycle, pushes the model's expectation, then waits past the edge.
    task automatic step(input logic v, input logic [1:0] sel, input logic am, input logic [W-1:0] d);
        logic [1:0] lane;
        logic [3:0] nm;
        d_valid = v; select = sel; auto_mode = am; d_in = d;
        lane  = am ? m_ptr : sel;
        m_vld = 4'd0;
        m_fd  = 1'b0;
        if (v) begin
            m_q[lane]   = d;
            m_vld[lane] = 1'b1;
            if (am) m_ptr = m_ptr + 2'd1;
`ifdef DEMUX_FRAME_EN
            nm = m_mask | (4'b0001 << lane);
            if (nm == 4'b1111) begin
                m_mask = 4'd0;
                m_fd   = 1'b1;
            end else begin
                m_mask = nm;
            end
`else
            nm = 4'd0;
`endif
        end
        sb.push_back(snap());
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({q, qbar, q_valid, ptr, frame_done} !== {32'h0, 32'hFFFFFFFF, 4'h0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got q=%h qbar=%h v=%b ptr=%0d fd=%b", q, qbar, q_valid, ptr, frame_done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_manual();
        step(1'b1, 2'd2, 1'b0, 8'hA5);
        e = sb.pop_front();
        checks++;
        if ({q, qbar, q_valid, ptr, frame_done} !== e || q[23:16] !== 8'hA5 || qbar[23:16] !== 8'h5A) begin
            errors++;
            $display("FAIL manual_write: got q=%h qbar=%h v=%b ptr=%0d want q=%h qbar=%h v=%b ptr=%0d",
                     q, qbar, q_valid, ptr, e.q, e.qbar, e.v, e.p);
        end
        step(1'b0, 2'd2, 1'b0, 8'h00);
        e = sb.pop_front();
        checks++;
        if ({q, qbar, q_valid, ptr, frame_done} !== e) begin
            errors++;
            $display("FAIL manual_strobe_end: got v=%b q=%h want v=%b q=%h", q_valid, q, e.v, e.q);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] data [4];
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'(3 - i), 1'b1, data[i]);
            e = sb.pop_front();
            checks++;
            if ({q, qbar, q_valid, ptr, frame_done} !== e) begin
                errors++;
                $display("FAIL round_robin_%0d: got q=%h v=%b ptr=%0d fd=%b want q=%h v=%b ptr=%0d fd=%b",
                         i, q, q_valid, ptr, frame_done, e.q, e.v, e.p, e.fd);
            end
        end
        checks++;
        if (q !== 32'h44332211) begin
            errors++;
            $display("FAIL round_robin_lanes: got %h want 44332211", q);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 2'd1, 1'b0, 8'h5C);
        void'(sb.pop_front());
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({q, qbar, q_valid, ptr, frame_done} !== {32'h0, 32'hFFFFFFFF, 4'h0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got q=%h qbar=%h v=%b ptr=%0d fd=%b", q, qbar, q_valid, ptr, frame_done);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_duplicate();
        logic [1:0] lanes [6];
        lanes[0] = 2'd0; lanes[1] = 2'd0; lanes[2] = 2'd1;
        lanes[3] = 2'd2; lanes[4] = 2'd3; lanes[5] = 2'd0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, lanes[i], 1'b0, 8'($urandom_range(0, 255)));
            e = sb.pop_front();
            checks++;
            if ({q, qbar, q_valid, ptr, frame_done} !== e) begin
                errors++;
                $display("FAIL duplicate_%0d: got q=%h v=%b fd=%b want q=%h v=%b fd=%b",
                         i, q, q_valid, frame_done, e.q, e.v, e.fd);
            end
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'(i), 1'(i), 8'($urandom_range(0, 255)));
            e = sb.pop_front();
            checks++;
            if ({q, qbar, q_valid, ptr, frame_done} !== e) begin
                errors++;
                $display("FAIL idle_%0d: got q=%h v=%b ptr=%0d want q=%h v=%b ptr=%0d",
                         i, q, q_valid, ptr, e.q, e.v, e.p);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'd1, (i % 3) != 2, 8'($urandom_range(0, 255)));
            e = sb.pop_front();
            checks++;
            if ({q, qbar, q_valid, ptr, frame_done} !== e) begin
                errors++;
                $display("FAIL back_to_back_%0d: got q=%h v=%b ptr=%0d fd=%b want q=%h v=%b ptr=%0d fd=%b",
                         i, q, q_valid, ptr, frame_done, e.q, e.v, e.p, e.fd);
            end
        end
        step(1'b1, 2'd3, 1'b0, 8'h3C);
        step(1'b1, 2'd3, 1'b0, 8'hC3);
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            checks++;
            if (i == 1 && ({q, qbar, q_valid, ptr, frame_done} !== e)) begin
                errors++;
                $display("FAIL same_lane_repeat: got q=%h v=%b want q=%h v=%b", q, q_valid, e.q, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_round_robin();
        test_async_reset();
        test_duplicate();
        test_idle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_dff.md
# demux_dff

Registered 1-to-4 demultiplexer with complementary outputs: the distribution end of the mux-into-flop path. A single data word is captured into one of four output registers chosen by an explicit select or by an internal round-robin pointer. It has a per-lane write strobe and an optional frame-complete indication. It sits where a shared bus or serial stage fans out to four registered consumers that each need `q` and `qbar`.

## Interface
- `WIDTH`, default 8: data width per lane, minimum 1.
- `clk`  input  1: clock; all state changes on the rising edge.
- `rst`  input  1: asynchronous, active-low reset (asserted when 0).
- `d_in`  input  WIDTH: data word to distribute.
- `d_valid`  input  1: write request; `d_in` is captured when 1 at a rising edge.
- `select`  input  2: target lane in manual mode.
- `auto_mode`  input  1: 1 = target is the round-robin pointer; 0 = target is `select`.
- `q`  output  4*WIDTH: lane registers; lane k occupies bits [k*WIDTH +: WIDTH].
- `qbar`  output  4*WIDTH: bitwise complement of `q`, registered.
- `q_valid`  output  4: one-cycle strobe per lane, set the cycle after that lane is written.
- `ptr`  output  2: current round-robin pointer.
- `frame_done`  output  1: one-cycle pulse when all four lanes have been written since the last frame (see Configuration).

## Operation
- Target lane: `auto_mode ? ptr : select`, sampled at the same edge as `d_valid`.
- Accepted write (`d_valid`=1):
  - the target lane's `q` takes `d_in`, and its `qbar` takes `~d_in`;
  - the other lanes hold.
- No write (`d_valid`=0): all lanes hold; `ptr` and the mask hold.
- Pointer:
  - increments by 1 on each accepted write with `auto_mode`=1, wrapping 3 -> 0;
  - holds in manual mode;
  - is not cleared by toggling `auto_mode`.
- Write mask (4 bits, internal): the bit for the target lane is set on each accepted write.
  - Repeated writes to the same lane leave the mask unchanged.
  - If the mask, including the current write, equals 4'b1111, the mask clears to 0 at that edge and `frame_done` is 1 for the following cycle.
- Reset (`rst`=0, at any time including mid-frame), immediately and without waiting for a clock edge:
  - `q`=0, `qbar`=all ones;
  - `q_valid`=0, `ptr`=0, mask=0, `frame_done`=0.
- Reset release: the first rising edge with `rst`=1 is a normal operating edge.
- Invariant: `qbar == ~q` at all times outside of the reset assertion instant.

## Timing
- Data latency: `q`/`qbar` of the target lane update at the same rising edge that samples `d_valid`=1, so the new value is visible one clock after presentation.
- `q_valid[k]` is registered:
  - it is high for exactly the cycle following the write edge to lane k;
  - it stays high on consecutive cycles only if lane k is written on consecutive edges.
- `frame_done` is registered and aligned with the `q_valid` strobe of the write that completed the frame.
- Back-to-back writes every cycle are supported: with `auto_mode`=1, four consecutive writes fill lanes 0..3 and `frame_done` pulses on the 4th strobe cycle.
- Simultaneous events:
  - a write that completes the mask also starts a fresh, empty mask;
  - a write in the same cycle as reset deassertion is ignored only if `rst` is still 0 at that edge.

## Configuration
- `DEMUX_FRAME_EN` defined:
  - the write mask and `frame_done` logic are present, with the behaviour above.
- `DEMUX_FRAME_EN` undefined:
  - the mask is not implemented and `frame_done` is tied to 0;
  - all other behaviour is identical, and the port list is unchanged.

## Test plan
- Reset: drive `rst`=0 mid-run after lanes hold data -> immediately `q`=0, `qbar`=32'hFFFFFFFF (WIDTH=8), `q_valid`=0, `ptr`=0, without any clock edge.
- Manual writes: `auto_mode`=0, `select`=2, `d_in`=8'hA5, `d_valid`=1 for one cycle -> lane 2 = A5, lane 2 `qbar` = 5A, other lanes unchanged, `q_valid`=4'b0100 for one cycle, `ptr` stays 0.
- Round-robin: `auto_mode`=1, four back-to-back writes 8'h11, 22, 33, 44 -> lanes 0..3 = 11, 22, 33, 44; `ptr` sequence 1, 2, 3, 0; `frame_done`=1 only on the 4th strobe cycle (with `DEMUX_FRAME_EN`).
- Duplicate lane: manual writes to lanes 0, 0, 1, 2 -> no `frame_done`; a following write to lane 3 -> `frame_done` pulse; the next write to lane 0 alone -> no pulse.
- Idle hold: `d_valid`=0 for 10 cycles with toggling `select`/`d_in`/`auto_mode` -> `q`, `ptr` and the mask unchanged, `q_valid`=0.
- Build without `DEMUX_FRAME_EN`: repeat the round-robin scenario -> identical `q`/`q_valid`/`ptr`, and `frame_done` is constantly 0.
